// File: rtl/video_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_pkg
// Shared types and constants for the video test-pattern generator.
// Revision : 1.0
// ============================================================================
package video_pattern_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID      = 3'd0,
    PAT_BARS       = 3'd1,
    PAT_GRADIENT   = 3'd2,
    PAT_CHECKER    = 3'd3,
    PAT_MOVING_BAR = 3'd4
  } pattern_e;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } rgb_t;

  // Field order mirrors the 32-bit config word, MSB first.
  typedef struct packed {
    logic [7:0] blu;
    logic [7:0] grn;
    logic [7:0] red;
    logic [4:0] rsvd;
    logic [2:0] pattern;
  } cfg_t;

  localparam rgb_t RGB_WHITE = '{red: 8'hFF, grn: 8'hFF, blu: 8'hFF};
  localparam rgb_t RGB_BLACK = '{red: 8'h00, grn: 8'h00, blu: 8'h00};

  localparam rgb_t BAR_COLOURS [8] = '{
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'h00, 8'h00, 8'h00}
  };

  localparam cfg_t CFG_RESET = '{blu: 8'h00, grn: 8'h00, red: 8'h00,
                                 rsvd: 5'd0, pattern: PAT_BARS};

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : video_raster_counter
// Raster position, colour-bar and frame counters with current/next views.
// Revision : 1.0
// ============================================================================
module video_raster_counter
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_advance,
  output logic [cnt_width(H_ACTIVE)-1:0] o_x,
  output logic [cnt_width(V_ACTIVE)-1:0] o_y,
  output logic [FRAME_CNT_W-1:0]        o_frame_cnt,
  output logic [cnt_width(H_ACTIVE)-1:0] o_x_nxt,
  output logic [cnt_width(V_ACTIVE)-1:0] o_y_nxt,
  output logic [2:0]                    o_bar_idx_nxt,
  output logic [FRAME_CNT_W-1:0]        o_frame_cnt_nxt
);

  localparam int X_W   = cnt_width(H_ACTIVE);
  localparam int Y_W   = cnt_width(V_ACTIVE);
  localparam int BAR_W = cnt_width(H_ACTIVE / 8);

  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(H_ACTIVE / 8 - 1);

  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  logic [BAR_W-1:0]       bar_sub_q, bar_sub_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // bar_sub divides x into eight equal bars without a divider.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    bar_idx_d   = bar_idx_q;
    bar_sub_d   = bar_sub_q;
    frame_cnt_d = frame_cnt_q;
    if (i_advance) begin
      if (x_q == X_LAST) begin
        x_d       = '0;
        bar_idx_d = '0;
        bar_sub_d = '0;
        if (y_q == Y_LAST) begin
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
        if (bar_sub_q == BAR_LAST) begin
          bar_sub_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_sub_d = bar_sub_q + BAR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q         <= '0;
      y_q         <= '0;
      bar_idx_q   <= '0;
      bar_sub_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      bar_idx_q   <= bar_idx_d;
      bar_sub_q   <= bar_sub_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_x             = x_q;
  assign o_y             = y_q;
  assign o_frame_cnt     = frame_cnt_q;
  assign o_x_nxt         = x_d;
  assign o_y_nxt         = y_d;
  assign o_bar_idx_nxt   = bar_idx_d;
  assign o_frame_cnt_nxt = frame_cnt_d;

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Valid/ready raster RGB test-pattern source with frame-aligned config.
// Optional white border overlay: define VIDEO_PATTERN_BORDER_EN.
// Revision : 1.0
// ============================================================================
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_cfg_valid,
  input  logic [31:0]            i_cfg_data,
  output logic                   o_rgb_valid,
  input  logic                   i_rgb_ready,
  output logic [7:0]             o_rgb_red,
  output logic [7:0]             o_rgb_grn,
  output logic [7:0]             o_rgb_blu,
  output logic                   o_sof,
  output logic                   o_eol,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  localparam int X_W = cnt_width(H_ACTIVE);
  localparam int Y_W = cnt_width(V_ACTIVE);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0]         cur_x, x_nxt;
  logic [Y_W-1:0]         cur_y, y_nxt;
  logic [2:0]             bar_idx_nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt_nxt;

  logic xfer, load, frame_end;

  logic valid_q, valid_d;
  rgb_t rgb_q, rgb_d;
  logic sof_q, sof_d;
  logic eol_q, eol_d;
  cfg_t pending_q, pending_d;
  cfg_t active_q, active_d;
  logic pend_flag_q, pend_flag_d;

  rgb_t        pix;
  logic [15:0] x_ext, y_ext, f_ext;
  logic        unused_ext_bits;

  video_raster_counter #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .FRAME_CNT_W (FRAME_CNT_W)
  ) u_raster (
    .clk             (clk),
    .rstn            (rstn),
    .i_advance       (xfer),
    .o_x             (cur_x),
    .o_y             (cur_y),
    .o_frame_cnt     (o_frame_cnt),
    .o_x_nxt         (x_nxt),
    .o_y_nxt         (y_nxt),
    .o_bar_idx_nxt   (bar_idx_nxt),
    .o_frame_cnt_nxt (frame_cnt_nxt)
  );

  // Before the first valid cycle the output stage loads pixel (0,0) unconditionally.
  always_comb begin
    xfer      = valid_q & i_rgb_ready;
    load      = xfer | ~valid_q;
    frame_end = xfer && (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  always_comb begin
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    active_d    = active_q;
    if (i_cfg_valid) begin
      pending_d   = cfg_t'(i_cfg_data);
      pend_flag_d = 1'b1;
    end
    if (frame_end && pend_flag_d) begin
      active_d    = pending_d;
      pend_flag_d = 1'b0;
    end
  end

  assign x_ext           = 16'(x_nxt);
  assign y_ext           = 16'(y_nxt);
  assign f_ext           = 16'(frame_cnt_nxt);
  assign unused_ext_bits = ^{x_ext[15:10], y_ext[15:8], f_ext[15:8]};

  // Colour of the pixel that will be presented next, using the pattern in force for it.
  always_comb begin
    pix = RGB_BLACK;
    case (active_d.pattern)
      PAT_SOLID:      pix = '{red: active_d.red, grn: active_d.grn, blu: active_d.blu};
      PAT_BARS:       pix = BAR_COLOURS[bar_idx_nxt];
      PAT_GRADIENT:   pix = '{red: x_ext[7:0], grn: y_ext[7:0], blu: f_ext[7:0]};
      PAT_CHECKER:    pix = (x_ext[5] ^ y_ext[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_MOVING_BAR: pix = (x_ext[9:3] == f_ext[6:0]) ? RGB_WHITE : RGB_BLACK;
      default:        pix = RGB_BLACK;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if ((x_nxt == '0) || (x_nxt == X_LAST) || (y_nxt == '0) || (y_nxt == Y_LAST)) begin
      pix = RGB_WHITE;
    end
`endif
  end

  always_comb begin
    valid_d = 1'b1;
    rgb_d   = rgb_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    if (load) begin
      rgb_d = pix;
      sof_d = (x_nxt == '0) && (y_nxt == '0);
      eol_d = (x_nxt == X_LAST);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= 1'b0;
      rgb_q       <= RGB_BLACK;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      pending_q   <= CFG_RESET;
      active_q    <= CFG_RESET;
      pend_flag_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rgb_q       <= rgb_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  assign o_rgb_valid = valid_q;
  assign o_rgb_red   = rgb_q.red;
  assign o_rgb_grn   = rgb_q.grn;
  assign o_rgb_blu   = rgb_q.blu;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pattern_gen
// Self-checking bench for video_pattern_gen against a frame-level pixel model.
// Revision : 1.0
// ============================================================================
module tb_video_pattern_gen;

  localparam int H  = 64;
  localparam int V  = 40;
  localparam int HV = H * V;

  logic        clk;
  logic        rstn;
  logic        i_cfg_valid;
  logic [31:0] i_cfg_data;
  logic        o_rgb_valid;
  logic        i_rgb_ready;
  logic [7:0]  o_rgb_red, o_rgb_grn, o_rgb_blu;
  logic        o_sof, o_eol;
  logic [7:0]  o_frame_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: transfers since reset, pattern config in force and pending.
  int          m_n;
  bit          m_valid;
  logic [31:0] m_cur, m_pend;
  bit          m_flag;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .FRAME_CNT_W (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_data  (i_cfg_data),
    .o_rgb_valid (o_rgb_valid),
    .i_rgb_ready (i_rgb_ready),
    .o_rgb_red   (o_rgb_red),
    .o_rgb_grn   (o_rgb_grn),
    .o_rgb_blu   (o_rgb_blu),
    .o_sof       (o_sof),
    .o_eol       (o_eol),
    .o_frame_cnt (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] dut_vec();
    return {o_rgb_valid, o_sof, o_eol, o_frame_cnt, o_rgb_red, o_rgb_grn, o_rgb_blu};
  endfunction

  function automatic logic [23:0] dut_rgb();
    return {o_rgb_red, o_rgb_grn, o_rgb_blu};
  endfunction

  function automatic logic [34:0] exp_vec();
    int x, y, f;
    logic [23:0] c;
    if (!m_valid) return '0;
    x = m_n % H;
    y = (m_n / H) % V;
    f = (m_n / HV) % 256;
    case (m_cur[2:0])
      3'd0: c = {m_cur[15:8], m_cur[23:16], m_cur[31:24]};
      3'd1: c = bar_tab[x / (H / 8)];
      3'd2: c = {8'(x % 256), 8'(y % 256), 8'(f)};
      3'd3: c = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      3'd4: c = (((x / 8) % 128) == (f % 128)) ? 24'hFFFFFF : 24'h000000;
      default: c = 24'h000000;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) c = 24'hFFFFFF;
`endif
    return {1'b1, (x == 0 && y == 0), (x == H - 1), 8'(f), c};
  endfunction

  task automatic model_reset();
    m_n     = 0;
    m_valid = 0;
    m_cur   = 32'h0000_0001;
    m_pend  = 32'h0000_0001;
    m_flag  = 0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
  task automatic drive_cycle(input bit rdy, input bit cv, input logic [31:0] cd);
    i_rgb_ready = rdy;
    i_cfg_valid = cv;
    i_cfg_data  = cd;
    @(posedge clk);
    #1;
    i_cfg_valid = 1'b0;
    if (cv) begin
      m_pend = cd;
      m_flag = 1;
    end
    if (m_valid && rdy) begin
      if ((m_n % HV) == HV - 1 && m_flag) begin
        m_cur  = m_pend;
        m_flag = 0;
      end
      m_n++;
    end
    m_valid = 1;
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    i_rgb_ready = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_data  = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (dut_vec() !== 35'd0) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=0", dut_vec());
      end
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 35'd0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=0", dut_vec());
    end
  endtask

  task automatic test_startup();
    drive_cycle(1, 0, '0);
    checks++;
    if ({o_rgb_valid, o_sof, dut_rgb()} !== {2'b11, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL first_pixel got=%h exp=%h", {o_rgb_valid, o_sof, dut_rgb()}, {2'b11, 24'hFFFFFF});
    end
    while (m_n < H) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL line0 n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
`ifndef VIDEO_PATTERN_BORDER_EN
      if (m_n == H / 8) begin
        checks++;
        if (dut_rgb() !== 24'hFFFF00) begin
          errors++;
          $display("FAIL bar1_yellow got=%h exp=ffff00", dut_rgb());
        end
      end
      if (m_n == H - 1) begin
        checks++;
        if ({o_eol, dut_rgb()} !== {1'b1, 24'h000000}) begin
          errors++;
          $display("FAIL last_px_black_eol got=%h exp=%h", {o_eol, dut_rgb()}, {1'b1, 24'h0});
        end
      end
`endif
    end
  endtask

  task automatic test_full_frame();
    int eols = 0;
    int n0 = m_n;
    while (m_n < HV) begin
      if (o_eol) eols++;
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frame0 n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (eols !== (HV - n0) / H) begin
      errors++;
      $display("FAIL eol_count got=%0d exp=%0d", eols, (HV - n0) / H);
    end
    checks++;
    if ({o_frame_cnt, o_sof} !== {8'd1, 1'b1}) begin
      errors++;
      $display("FAIL frame_wrap got cnt=%0d sof=%b exp cnt=1 sof=1", o_frame_cnt, o_sof);
    end
  endtask

  task automatic test_random_ready();
    logic [34:0] prev;
    bit rdy;
    for (int i = 0; i < 1500; i++) begin
      prev = dut_vec();
      rdy  = bit'($urandom % 2);
      drive_cycle(rdy, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_stream n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
      if (!rdy) begin
        checks++;
        if (dut_vec() !== prev) begin
          errors++;
          $display("FAIL stall_hold got=%h exp=%h", dut_vec(), prev);
        end
      end
    end
  endtask

  task automatic test_config();
    int target;
    drive_cycle(1, 1, 32'h5634_1200);
    while ((m_n % HV) != 0) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cfg_tail n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
    end
`ifndef VIDEO_PATTERN_BORDER_EN
    checks++;
    if ({o_sof, dut_rgb()} !== {1'b1, 24'h123456}) begin
      errors++;
      $display("FAIL solid_first got=%h exp=%h", {o_sof, dut_rgb()}, {1'b1, 24'h123456});
    end
`endif
    target = m_n + HV;
    while (m_n < target) begin
      drive_cycle(($urandom % 4) != 0, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL solid_frame n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_last_wins_and_edge_write();
    int target;
    drive_cycle(1, 1, 32'h0000_0004);
    repeat (10) drive_cycle(1, 0, '0);
    drive_cycle(1, 1, 32'h0000_0002);
    while ((m_n % HV) != HV - 1) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pend_tail n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
    end
    drive_cycle(1, 1, 32'hFFEE_DD03);
    target = m_n + 32 * H + 32;
    while (m_n < target) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL checker n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
      if ((m_n % HV) == 32) begin
        checks++;
        if (dut_rgb() !== 24'hFFFFFF) begin
          errors++;
          $display("FAIL checker_32_0 got=%h exp=ffffff", dut_rgb());
        end
      end
    end
    checks++;
    if (dut_rgb() !== 24'h000000) begin
      errors++;
      $display("FAIL checker_32_32 got=%h exp=000000", dut_rgb());
    end
  endtask

  task automatic test_gradient();
    int target = 5 * HV + 20 * H + 10;
    drive_cycle(1, 1, 32'h0000_0002);
    while (m_n < target) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gradient n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (dut_rgb() !== {8'd10, 8'd20, 8'd5}) begin
      errors++;
      $display("FAIL gradient_10_20_f5 got=%h exp=%h", dut_rgb(), {8'd10, 8'd20, 8'd5});
    end
  endtask

  task automatic test_reset_midline();
    drive_cycle(1, 1, 32'hCCBB_AA00);
    repeat (5) drive_cycle(1, 0, '0);
    rstn = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 35'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", dut_vec());
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 35'd0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=0", dut_vec());
    end
    rstn = 1'b1;
    model_reset();
    while (m_n < HV + 2) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
      if (m_n == HV) begin
        checks++;
        if ({o_sof, o_frame_cnt, dut_rgb()} !== {1'b1, 8'd1, 24'hFFFFFF}) begin
          errors++;
          $display("FAIL pending_dropped got=%h exp=%h", {o_sof, o_frame_cnt, dut_rgb()}, {1'b1, 8'd1, 24'hFFFFFF});
        end
      end
    end
  endtask

`ifdef VIDEO_PATTERN_BORDER_EN
  task automatic test_border();
    int target;
    drive_cycle(1, 1, 32'h0000_0000);
    while ((m_n % HV) != 0) drive_cycle(1, 0, '0);
    target = m_n + 2 * H + 2;
    while (m_n < target) begin
      drive_cycle(1, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL border n=%0d got=%h exp=%h", m_n, dut_vec(), exp_vec());
      end
      if ((m_n % HV) == 5 || (m_n % HV) == 2 * H - 1) begin
        checks++;
        if (dut_rgb() !== 24'hFFFFFF) begin
          errors++;
          $display("FAIL border_white n=%0d got=%h exp=ffffff", m_n, dut_rgb());
        end
      end
      if ((m_n % HV) == H + 1) begin
        checks++;
        if (dut_rgb() !== 24'h000000) begin
          errors++;
          $display("FAIL border_inner got=%h exp=000000", dut_rgb());
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_full_frame();
    test_random_ready();
    test_config();
    test_last_wins_and_edge_write();
    test_gradient();
    test_reset_midline();
`ifdef VIDEO_PATTERN_BORDER_EN
    test_border();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
